instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FETCH_PROT, default 3'b100, value driven on arprot (instruction, secure, unprivileged).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports arvalid output 1, arready input 1, araddress output 32, arprot output 3; AXI4-lite read-address channel.
REQ-006 SHALL have ports rvalid input 1, rready output 1, rdata input 32, rresp input 1 (1 = error); AXI4-lite read-data channel.
REQ-007 SHALL have ports instr_valid output 1, instr_ready input 1, instr output 32, instr_pc output 32, instr_fault output 1; decoder-side handshake.
REQ-008 SHALL have ports redirect_valid input 1, redirect_pc input 32; branch/jump/trap target from execute.

Function
REQ-009 SHALL keep at most one outstanding AXI read.
REQ-010 SHALL implement states IDLE, ADDR, DATA, STALL: IDLE->ADDR when a buffer slot is free; ADDR->DATA on arvalid&arready; DATA->IDLE on rvalid&rready; any state->STALL on fault; STALL->ADDR only on redirect_valid.
REQ-011 SHALL hold arvalid high and araddress stable from assertion until arready, even across a redirect.
REQ-012 SHALL assert rready only in DATA.
REQ-013 SHALL advance fetch pc by 4 per accepted response, modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-014 SHALL present rdata on instr and the request address on instr_pc, with instr_valid rising the cycle after rvalid&rready.
REQ-015 SHALL hold instr, instr_pc, and instr_fault stable while instr_valid&!instr_ready.
REQ-016 SHALL, on redirect_valid, flush all buffered instructions (instr_valid low next cycle), set fetch pc to redirect_pc, and mark any in-flight read for discard.
REQ-017 SHALL drop a discarded response without presenting it, then issue at redirect_pc.
REQ-018 SHALL give redirect_valid priority over a same-cycle instr handshake; the handshaken instruction is considered consumed.
REQ-019 SHALL, when rresp=1, present instr=32'h0, instr_fault=1, instr_valid=1 at that pc, then enter STALL.
REQ-020 SHALL, when redirect_pc[1:0]!=0, issue no read and present instr_fault=1, instr=32'h0, instr_pc=redirect_pc, then enter STALL.
REQ-021 SHALL drive arprot=FETCH_PROT constantly.

Reset
REQ-022 SHALL, while reset=0, force arvalid=0, rready=0, instr_valid=0, instr_fault=0, instr=0, instr_pc=0, fetch pc=RESET_PC, state=IDLE, buffer empty, discard flag clear.
REQ-023 SHALL assert arvalid with araddress=RESET_PC on the first rising edge after reset deasserts.
REQ-024 SHALL treat reset mid-transaction as abandoning it; the interconnect is reset together with this block.

Configuration
REQ-025 SHALL, with FETCH_PREFETCH_EN defined, use a 2-entry instruction FIFO and issue the next read while an instruction waits on instr_ready, given a free slot.
REQ-026 SHALL, without FETCH_PREFETCH_EN, use a single output register and issue the next read only after the current instruction handshakes.

Structure
REQ-027 SHALL take state encoding, AXI response codes, and the instruction-width constant from shared package riscv_pkg.
REQ-028 SHALL place the prefetch buffer in sub-module fetch_fifo (depth 1 or 2, with flush input).

Verification
REQ-029 Reset release, arready=1, memory returns 32'h0000_0013 at 0x0 and 0x4 with one-cycle latency -> instr_pc=0x0 then 0x4, instr=32'h0000_0013, instr_fault=0.
REQ-030 arready held low 5 cycles -> arvalid stays 1, araddress stays 0x0 throughout.
REQ-031 redirect_pc=0x100 while read of 0x8 is in DATA -> 0x8 data never presented; next araddress=0x100.
REQ-032 rresp=1 on 0x4 -> instr_fault=1, instr=0, instr_pc=0x4; no arvalid until redirect_valid with 0x200.
REQ-033 redirect_pc=0x102 -> instr_fault=1, instr_pc=0x102, no arvalid issued.
REQ-034 instr_ready low 4 cycles with FETCH_PREFETCH_EN -> exactly one extra read issued, outputs stable; without the macro -> no read until handshake.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side constants: FSM state codes, AXI read response codes,
// instruction width and the buffered-instruction record.
package riscv_pkg;
  localparam int ILEN = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STALL = 2'd3;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  typedef struct packed {
    logic            fault;
    logic [31:0]     pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Shift-style instruction buffer, 1 or 2 deep; head is always slot 0 so the
// presented instruction never moves while it waits. Flush drops everything.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output logic         valid,
  output logic         full,
  output fetch_entry_t head
);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem [DEPTH];
  logic [CW-1:0]  cnt;
  logic           do_pop, do_push;
  logic [CW-1:0]  widx;

  assign valid   = cnt != '0;
  assign full    = cnt == CW'(DEPTH);
  assign head    = mem[0];
  assign do_pop  = pop & valid;
  assign do_push = push & (!full | do_pop);
  assign widx    = cnt - CW'(do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // a flush may carry one new entry (a fault record for a bad target)
      cnt <= CW'(push);
      if (push) mem[0] <= wdata;
    end else begin
      if (do_pop)
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      if (do_push)
        for (int i = 0; i < DEPTH; i++)
          if (CW'(i) == widx) mem[i] <= wdata;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// AXI4-lite instruction fetch, one read in flight, redirect/flush and fault stall.
// FETCH_PREFETCH_EN selects a 2-deep buffer so a read can overlap a decoder stall.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [2:0]  FETCH_PROT = 3'b100
) (
  input  logic            clk,
  input  logic            reset,
  output logic            arvalid,
  input  logic            arready,
  output logic [31:0]     araddress,
  output logic [2:0]      arprot,
  input  logic            rvalid,
  output logic            rready,
  input  logic [ILEN-1:0] rdata,
  input  logic            rresp,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [31:0]     instr_pc,
  output logic            instr_fault,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc
);
`ifdef FETCH_PREFETCH_EN
  localparam int FIFO_DEPTH = 2;
`else
  localparam int FIFO_DEPTH = 1;
`endif

  logic [1:0]   state;
  logic [31:0]  fetch_pc, req_addr;
  logic         discard, halt;
  logic         redir_bad, resp_take, push, pop, fifo_full;
  fetch_entry_t wentry, head;

  assign arvalid   = state == ST_ADDR;
  assign rready    = state == ST_DATA;
  assign araddress = req_addr;
  assign arprot    = FETCH_PROT;

  assign redir_bad = redirect_valid & pc_misaligned(redirect_pc);
  assign resp_take = (state == ST_DATA) & rvalid & !discard & !redirect_valid;
  assign pop       = instr_valid & instr_ready & !redirect_valid;

  always_comb begin
    push   = 1'b0;
    wentry = '0;
    if (redir_bad) begin
      push         = 1'b1;
      wentry.fault = 1'b1;
      wentry.pc    = redirect_pc;
    end else if (resp_take) begin
      push         = 1'b1;
      wentry.fault = rresp == RESP_ERR;
      wentry.pc    = req_addr;
      wentry.instr = (rresp == RESP_ERR) ? '0 : rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      discard  <= 1'b0;
      halt     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            if (redir_bad) state <= ST_STALL;
          end else if (!fifo_full) begin
            state    <= ST_ADDR;
            req_addr <= fetch_pc;
          end
        ST_ADDR: begin
          // address stays put until accepted; a redirect only tags the read
          if (arready) state <= ST_DATA;
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            discard  <= 1'b1;
            halt     <= redir_bad;
          end
        end
        ST_DATA:
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            halt     <= redir_bad;
            if (rvalid) begin
              discard <= 1'b0;
              state   <= redir_bad ? ST_STALL : ST_IDLE;
            end else begin
              discard <= 1'b1;
            end
          end else if (rvalid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= halt ? ST_STALL : ST_IDLE;
            end else begin
              fetch_pc <= fetch_pc + 32'd4;
              state    <= (rresp == RESP_ERR) ? ST_STALL : ST_IDLE;
            end
          end
        ST_STALL:
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            halt     <= redir_bad;
            if (!redir_bad) begin
              state    <= ST_ADDR;
              req_addr <= redirect_pc;
            end
          end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .valid (instr_valid),
    .full  (fifo_full),
    .head  (head)
  );

  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign instr_fault = head.fault;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: AXI slave model plus an architectural fetch-stream
// model (expected pc sequence, redirects, faults) checked every cycle.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        arvalid, arready;
  logic [31:0] araddress;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic        rresp;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        instr_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .reset(reset),
    .arvalid(arvalid), .arready(arready), .araddress(araddress), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_fault(instr_fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int n_chk = 0, n_fail = 0;

  // fetch-stream model
  logic [31:0] exp_pc, exp_ar_pc;
  bit          stalled, stalled_err, no_new_ar, exp_ar_vld;
  int          consumed, ar_hs_cnt;
  // memory slave
  bit          pend, err_mode, last_ar_hs;
  logic [31:0] paddr, err_addr, last_ar_addr;
  int          lat, ar_pct, lat_min, lat_max;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'h10) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    return err_mode ? (a[8:2] == 7'h2B) : (a == err_addr);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_slave();
    arready = $urandom_range(99, 0) < ar_pct;
    if (pend && lat == 0) begin
      rvalid = 1'b1;
      rresp  = is_err(paddr);
      rdata  = is_err(paddr) ? $urandom : mem_word(paddr);
    end else begin
      rvalid = 1'b0;
      rresp  = 1'b0;
      rdata  = $urandom;
      if (pend) lat--;
    end
  endtask

  // One clock: evaluate handshakes mid-cycle, advance, then check after the edge.
  task automatic step();
    bit ih, ah, rh, redir, hold, ar_hold, f;
    logic [31:0] h_instr, h_pc, h_ar, rpc;
    logic h_fault;
    #3;
    ih = instr_valid & instr_ready;  ah = arvalid & arready;
    rh = rvalid & rready;            redir = redirect_valid;  rpc = redirect_pc;
    if (rready) check("rready_without_read", pend, 1);
    last_ar_hs = ah;
    if (ah) begin
      check("one_outstanding", pend, 0);
      ar_hs_cnt++;
      last_ar_addr = araddress;
    end
    if (ih) begin
      check("hs_while_stalled", stalled, 0);
      if (!stalled) begin
        f = (exp_pc[1:0] != 2'b00) || is_err(exp_pc);
        check("instr_pc", instr_pc, exp_pc);
        check("instr_fault", instr_fault, f);
        check("instr", instr, f ? 32'h0 : mem_word(exp_pc));
        consumed++;
        if (f) begin stalled = 1; stalled_err = exp_pc[1:0] == 2'b00; end
        else exp_pc += 32'd4;
      end
    end
    hold = instr_valid & !instr_ready & !redir;
    h_instr = instr; h_pc = instr_pc; h_fault = instr_fault;
    ar_hold = arvalid & !arready;
    h_ar = araddress;
    if (redir) begin
      exp_pc = rpc; stalled = 0; stalled_err = 0;
      if (rpc[1:0] != 2'b00) begin no_new_ar = 1; exp_ar_vld = 0; end
      else begin no_new_ar = 0; exp_ar_vld = 1; exp_ar_pc = rpc; end
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    if (hold) begin
      check("hold_valid", instr_valid, 1);
      check("hold_instr", instr, h_instr);
      check("hold_pc", instr_pc, h_pc);
      check("hold_fault", instr_fault, h_fault);
    end
    if (redir) begin
      check("flush_valid", instr_valid, rpc[1:0] != 2'b00);
      if (rpc[1:0] != 2'b00) begin
        check("bad_target_fault", instr_fault, 1);
        check("bad_target_pc", instr_pc, rpc);
        check("bad_target_instr", instr, 0);
      end
    end
    if (ar_hold) begin
      check("ar_hold_valid", arvalid, 1);
      check("ar_hold_addr", araddress, h_ar);
    end
    if (arvalid && !ar_hold) begin
      check("ar_after_bad_target", no_new_ar, 0);
      if (exp_ar_vld) begin
        check("ar_redirect_addr", araddress, exp_ar_pc);
        exp_ar_vld = 0;
      end
    end
    if (stalled_err) check("stall_arvalid", arvalid, 0);
    if (rh) pend = 0;
    if (ah) begin pend = 1; paddr = h_ar; lat = $urandom_range(lat_max, lat_min); end
    drive_slave();
  endtask

  task automatic do_reset();
    reset = 1'b0; redirect_valid = 1'b0; arready = 1'b0; rvalid = 1'b0;
    rresp = 1'b0; rdata = '0;
    pend = 0; lat = 0; exp_pc = 32'h0; stalled = 0; stalled_err = 0;
    no_new_ar = 0; exp_ar_vld = 0; consumed = 0; ar_hs_cnt = 0; last_ar_hs = 0;
    #1;
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr_fault", instr_fault, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("first_arvalid", arvalid, 1);
    check("first_araddress", araddress, 32'h0);
    drive_slave();
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
  endtask

  task automatic wait_cons(input int target, input int budget, input string tag);
    int k = 0;
    while (consumed < target && k < budget) begin step(); k++; end
    check(tag, consumed >= target, 1);
  endtask

  initial begin
    int k, base;
    reset = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 1'b0;
    err_mode = 0; err_addr = 32'hFFFF_FFFF; ar_pct = 100; lat_min = 0; lat_max = 0;

    // basic stream, one-cycle memory
    do_reset();
    check("arprot", arprot, 3'b100);
    instr_ready = 1'b1;
    wait_cons(2, 20, "t_basic_progress");

    // address channel back-pressure
    ar_pct = 0;
    do_reset();
    repeat (5) begin
      step();
      check("bp_arvalid", arvalid, 1);
      check("bp_araddress", araddress, 32'h0);
    end
    ar_pct = 100;
    wait_cons(1, 20, "t_bp_progress");

    // redirect while 0x8 is in its data phase
    lat_min = 3; lat_max = 3;
    do_reset();
    k = 0;
    while (!(last_ar_hs && last_ar_addr == 32'h8) && k < 40) begin step(); k++; end
    check("t_redir_saw_0x8", last_ar_hs && last_ar_addr == 32'h8, 1);
    redirect(32'h100);
    wait_cons(consumed + 2, 40, "t_redir_progress");
    lat_min = 0; lat_max = 0;

    // error response at 0x4 stalls until redirect
    err_addr = 32'h4;
    do_reset();
    wait_cons(2, 30, "t_err_progress");
    repeat (5) step();
    err_addr = 32'hFFFF_FFFF;
    redirect(32'h200);
    wait_cons(consumed + 1, 30, "t_err_recover");

    // misaligned redirect target
    redirect(32'h102);
    wait_cons(consumed + 1, 10, "t_bad_target_fault");
    repeat (6) step();
    redirect(32'h300);
    wait_cons(consumed + 2, 30, "t_bad_target_recover");

    // pc wraps at the top of the address space
    redirect(32'hFFFF_FFF8);
    wait_cons(consumed + 3, 40, "t_wrap_progress");

    // decoder stall: prefetch overlaps exactly one read
    do_reset();
    instr_ready = 1'b0;
    k = 0;
    while (!instr_valid && k < 20) begin step(); k++; end
    check("t_stall_first_valid", instr_valid, 1);
    base = ar_hs_cnt;
    repeat (4) step();
`ifdef FETCH_PREFETCH_EN
    check("t_stall_extra_reads", ar_hs_cnt - base, 1);
`else
    check("t_stall_extra_reads", ar_hs_cnt - base, 0);
`endif
    check("t_stall_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    wait_cons(2, 20, "t_stall_progress");

    // randomized traffic
    err_mode = 1; ar_pct = 70; lat_min = 0; lat_max = 3;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      instr_ready = $urandom_range(9, 0) < 7;
      if (stalled ? ($urandom_range(3, 0) == 0) : ($urandom_range(39, 0) == 0)) begin
        redirect_valid = 1'b1;
        redirect_pc = 32'h1000 + ($urandom_range(255, 0) << 2);
        if ($urandom_range(7, 0) == 0) redirect_pc[1:0] = 2'($urandom_range(3, 1));
      end
      step();
    end
    check("rand_progress", consumed > 300, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
